// File: rtl/mux_8x1.sv
// mux_8x1: eight-way WIDTH-bit selector built as a balanced tree of
// 2:1 stages, with an optional registered copy of the selected data.
//
// Ports:
//   clk      - datapath clock, rising edge, feeds only the result_q flops
//   reset    - asynchronous active-high clear of result_q
//   in0..in7 - data inputs, inN chosen by select == N
//   select   - 3-bit unsigned selection code
//   result   - combinational selected data
//   result_q - registered selected data when MUX8X1_REG_OUT_EN is
//              defined, otherwise a combinational copy of result
//
// Build option: define MUX8X1_REG_OUT_EN to instantiate the output flops.

module mux_8x1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q
);

  // AND-OR form keeps each stage gate-level; an X select bit
  // propagates X rather than silently picking a side.
  function automatic logic [WIDTH-1:0] mux2(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             s
  );
    logic [WIDTH-1:0] sv;
    sv = {WIDTH{s}};
    return (a & ~sv) | (b & sv);
  endfunction

  logic [WIDTH-1:0] l0 [4];
  logic [WIDTH-1:0] l1 [2];

  assign l0[0] = mux2(in0, in1, select[0]);
  assign l0[1] = mux2(in2, in3, select[0]);
  assign l0[2] = mux2(in4, in5, select[0]);
  assign l0[3] = mux2(in6, in7, select[0]);

  assign l1[0] = mux2(l0[0], l0[1], select[1]);
  assign l1[1] = mux2(l0[2], l0[3], select[1]);

  assign result = mux2(l1[0], l1[1], select[2]);

`ifdef MUX8X1_REG_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end
`else
  assign result_q = result;

  // clk and reset have no load in the unregistered build.
  logic unused;
  assign unused = clk ^ reset;
`endif

endmodule

// File: tb/tb_mux_8x1.sv
// tb_mux_8x1: randomized and directed checks of mux_8x1 at WIDTH 1 and 8
// against an array-indexing reference model.

module tb_mux_8x1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] sel = 3'd0;
  logic [7:0] wi [8];
  logic       bi [8];
  logic [7:0] wr;
  logic [7:0] wq;
  logic       br;
  logic       bq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_8x1 #(.WIDTH(8)) dut_w (
    .clk(clk), .reset(reset),
    .in0(wi[0]), .in1(wi[1]), .in2(wi[2]), .in3(wi[3]),
    .in4(wi[4]), .in5(wi[5]), .in6(wi[6]), .in7(wi[7]),
    .select(sel), .result(wr), .result_q(wq)
  );

  mux_8x1 #(.WIDTH(1)) dut_b (
    .clk(clk), .reset(reset),
    .in0(bi[0]), .in1(bi[1]), .in2(bi[2]), .in3(bi[3]),
    .in4(bi[4]), .in5(bi[5]), .in6(bi[6]), .in7(bi[7]),
    .select(sel), .result(br), .result_q(bq)
  );

  function automatic logic [7:0] ref_w(input logic [2:0] s);
    return wi[s];
  endfunction

  function automatic logic ref_b(input logic [2:0] s);
    return bi[s];
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      wi[k] = 8'(k * 3 + 1);
      bi[k] = k[0];
    end
    reset = 1'b1;
    sel = 3'd5;
    #1;
    checks++;
    if (wr !== ref_w(sel)) begin
      errors++;
      $display("FAIL reset_result got %h want %h", wr, ref_w(sel));
    end
`ifdef MUX8X1_REG_OUT_EN
    checks++;
    if (wq !== 8'h00) begin
      errors++;
      $display("FAIL reset_q got %h want 00", wq);
    end
`else
    checks++;
    if (wq !== ref_w(sel)) begin
      errors++;
      $display("FAIL reset_q_comb got %h want %h", wq, ref_w(sel));
    end
`endif
    #4;
    reset = 1'b0;
  endtask

  task automatic test_walk();
    logic [7:0] pat;
    logic [7:0] want;
    pat = 8'b1010_0111;
    want = 8'b1010_0111;
    for (int k = 0; k < 8; k++) bi[k] = pat[k];
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      #1;
      checks++;
      if (br !== want[k]) begin
        errors++;
        $display("FAIL walk sel=%0d got %b want %b", k, br, want[k]);
      end
      #19;
    end
  endtask

  task automatic test_isolation();
    sel = 3'b101;
    bi[5] = 1'b0;
    wi[5] = 8'h5a;
    #1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) begin
        if (k != 5) begin
          bi[k] = ~bi[k];
          wi[k] = 8'($urandom);
        end
      end
      #1;
      checks++;
      if (br !== 1'b0 || wr !== 8'h5a) begin
        errors++;
        $display("FAIL isolation got %b/%h want 0/5a", br, wr);
      end
    end
    bi[5] = 1'b1;
    #1;
    checks++;
    if (br !== 1'b1) begin
      errors++;
      $display("FAIL isolation_toggle got %b want 1", br);
    end
  endtask

  task automatic test_wide();
    for (int k = 0; k < 8; k++) wi[k] = 8'h10 + 8'(k);
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      #1;
      checks++;
      if (wr !== 8'h10 + 8'(k)) begin
        errors++;
        $display("FAIL wide sel=%0d got %h want %h", k, wr, 8'h10 + 8'(k));
      end
      #9;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 8; k++) begin
        wi[k] = 8'($urandom);
        bi[k] = 1'($urandom);
      end
      sel = 3'($urandom_range(0, 7));
      #1;
      checks++;
      if (wr !== ref_w(sel) || br !== ref_b(sel)) begin
        errors++;
        $display("FAIL random sel=%0d got %h/%b want %h/%b",
                 sel, wr, br, ref_w(sel), ref_b(sel));
      end
`ifndef MUX8X1_REG_OUT_EN
      checks++;
      if (wq !== ref_w(sel) || bq !== ref_b(sel)) begin
        errors++;
        $display("FAIL random_q_comb sel=%0d got %h/%b want %h/%b",
                 sel, wq, bq, ref_w(sel), ref_b(sel));
      end
`endif
      #2;
    end
  endtask

`ifdef MUX8X1_REG_OUT_EN
  task automatic test_registered();
    logic [7:0] qexp;
    @(negedge clk);
    reset = 1'b1;
    sel = 3'd3;
    for (int k = 0; k < 8; k++) bi[k] = 1'b0;
    bi[3] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bq !== 1'b0) begin
      errors++;
      $display("FAIL q_in_reset got %b want 0", bq);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bq !== 1'b0) begin
      errors++;
      $display("FAIL q_before_edge got %b want 0", bq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bq !== 1'b1) begin
      errors++;
      $display("FAIL q_first_capture got %b want 1", bq);
    end
    @(negedge clk);
    sel = 3'd4;
    bi[4] = 1'b0;
    #1;
    checks++;
    if (bq !== 1'b1) begin
      errors++;
      $display("FAIL q_hold got %b want 1", bq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bq !== 1'b0) begin
      errors++;
      $display("FAIL q_next got %b want 0", bq);
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) wi[k] = 8'($urandom);
      sel = 3'($urandom_range(0, 7));
      qexp = wi[sel];
      @(posedge clk);
      #1;
      checks++;
      if (wq !== qexp) begin
        errors++;
        $display("FAIL q_random got %h want %h", wq, qexp);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 3'd3;
    bi[3] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bq !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got %b want 1", bq);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bq !== 1'b0 || br !== 1'b1) begin
      errors++;
      $display("FAIL async_clear got q=%b r=%b want q=0 r=1", bq, br);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bq !== 1'b0 || wq !== 8'h00) begin
      errors++;
      $display("FAIL async_hold got %b/%h want 0/00", bq, wq);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`else
  task automatic test_comb_q();
    for (int k = 0; k < 8; k++) begin
      wi[k] = 8'($urandom);
      bi[k] = 1'($urandom);
    end
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      #1;
      checks++;
      if (wq !== wi[k] || bq !== bi[k]) begin
        errors++;
        $display("FAIL comb_q sel=%0d got %h/%b want %h/%b",
                 k, wq, bq, wi[k], bi[k]);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_walk();
    test_isolation();
    test_wide();
    test_random();
`ifdef MUX8X1_REG_OUT_EN
    test_registered();
    test_async_reset();
`else
    test_comb_q();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
